// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel generator.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 8
);
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (output hsync, vsync, de, x, y, line_start, frame_start, frame_count);
  modport slave  (input  hsync, vsync, de, x, y, line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, registered region
// decode, and a uniform output delay line of 1+PIPE_DLY stages.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8,
  parameter int PIPE_DLY  = 0
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             run,
  vga_timing_gen_if.master vo
);
  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

  if ((H_TOT - 1) > ((1 << CNT_W) - 1) || (V_TOT - 1) > ((1 << CNT_W) - 1) ||
      PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_cfg
    $error("vga_timing_gen: counter width too small or PIPE_DLY out of 0..4");
  end

  typedef struct packed {
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;
  } vout_t;

  localparam vout_t IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, de: 1'b0,
                             x: '0, y: '0, line_start: 1'b0, frame_start: 1'b0,
                             frame_count: '0};

  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  vout_t              st_d;
  vout_t [PIPE_DLY:0] st_q;
  int unsigned        h_i, v_i;

  assign h_i = 32'(h_q);
  assign v_i = 32'(v_q);

  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    fc_d = fc_q;
    st_d = IDLE;
    // frame_count is carried through even when idle so a stop never zeroes it
    st_d.frame_count = fc_q;
    if (!run) begin
      h_d = '0;
      v_d = '0;
    end else begin
      st_d.hsync       = (h_i >= HS_BEG && h_i < HS_END) ? HSYNC_POL : ~HSYNC_POL;
      st_d.vsync       = (v_i >= VS_BEG && v_i < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      st_d.de          = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
      st_d.x           = h_q;
      st_d.y           = v_q;
      st_d.line_start  = (h_q == '0);
      st_d.frame_start = (h_q == '0) && (v_q == '0);
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fc_d = fc_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      h_q  <= '0;
      v_q  <= '0;
      fc_q <= '0;
      st_q <= {(PIPE_DLY+1){IDLE}};
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      st_q[0] <= st_d;
      for (int i = 1; i <= PIPE_DLY; i++) st_q[i] <= st_q[i-1];
    end
  end

  assign vo.hsync       = st_q[PIPE_DLY].hsync;
  assign vo.vsync       = st_q[PIPE_DLY].vsync;
  assign vo.de          = st_q[PIPE_DLY].de;
  assign vo.x           = st_q[PIPE_DLY].x;
  assign vo.y           = st_q[PIPE_DLY].y;
  assign vo.line_start  = st_q[PIPE_DLY].line_start;
  assign vo.frame_start = st_q[PIPE_DLY].frame_start;
  assign vo.frame_count = st_q[PIPE_DLY].frame_count;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: directed expected vectors keyed by cycle, checked by a monitor.
module tb_vga_timing_gen;
  logic pixel_clk = 1'b0;
  logic rst_a = 1'b1, rst_s = 1'b1;
  logic run_a = 1'b1, run_s = 1'b1, run_p = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) vif0 ();
  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) vif2 ();
  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) vifp ();
  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(2)) vifs ();

  vga_timing_gen #(.PIPE_DLY(0)) u0 (.pixel_clk(pixel_clk), .reset(rst_a), .run(run_a), .vo(vif0));
  vga_timing_gen #(.PIPE_DLY(2)) u2 (.pixel_clk(pixel_clk), .reset(rst_a), .run(run_a), .vo(vif2));
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HSYNC_POL(1'b1), .VSYNC_POL(1'b1))
    up (.pixel_clk(pixel_clk), .reset(rst_a), .run(run_p), .vo(vifp));
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .FRAME_W(2))
    us (.pixel_clk(pixel_clk), .reset(rst_s), .run(run_s), .vo(vifs));

  always @(posedge pixel_clk or posedge rst_a)
    if (rst_a) cyc <= 0;
    else       cyc <= cyc + 1;

  typedef struct {
    int cyc; int dut;
    logic hs, vs, de; int x, y; logic ls, fs; int fc;
  } exp_t;

  exp_t sbq[$];
  exp_t hist[0:2047];

  task automatic e(input int c, input int d, input logic hs, input logic vs, input logic de,
                   input int x, input int y, input logic ls, input logic fs, input int fc);
    exp_t t;
    t = '{cyc: c, dut: d, hs: hs, vs: vs, de: de, x: x, y: y, ls: ls, fs: fs, fc: fc};
    sbq.push_back(t);
  endtask

  function automatic exp_t get_act(input int d);
    exp_t a;
    a = '{cyc: cyc, dut: d, hs: 1'b0, vs: 1'b0, de: 1'b0, x: 0, y: 0, ls: 1'b0, fs: 1'b0, fc: 0};
    case (d)
      0: a = '{cyc, d, vif0.hsync, vif0.vsync, vif0.de, int'(vif0.x), int'(vif0.y),
               vif0.line_start, vif0.frame_start, int'(vif0.frame_count)};
      1: a = '{cyc, d, vif2.hsync, vif2.vsync, vif2.de, int'(vif2.x), int'(vif2.y),
               vif2.line_start, vif2.frame_start, int'(vif2.frame_count)};
      2: a = '{cyc, d, vifp.hsync, vifp.vsync, vifp.de, int'(vifp.x), int'(vifp.y),
               vifp.line_start, vifp.frame_start, int'(vifp.frame_count)};
      default: a = '{cyc, d, vifs.hsync, vifs.vsync, vifs.de, int'(vifs.x), int'(vifs.y),
                     vifs.line_start, vifs.frame_start, int'(vifs.frame_count)};
    endcase
    return a;
  endfunction

  function automatic bit same_out(input exp_t a, input exp_t b);
    return a.hs === b.hs && a.vs === b.vs && a.de === b.de && a.x == b.x && a.y == b.y &&
           a.ls === b.ls && a.fs === b.fs && a.fc == b.fc;
  endfunction

  task automatic report(input string nm, input exp_t a, input exp_t w);
    $display("FAIL %s cyc=%0d dut=%0d got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
             nm, cyc, w.dut, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, a.fc,
             w.hs, w.vs, w.de, w.x, w.y, w.ls, w.fs, w.fc);
  endtask

  // Monitor: pops every expectation due this cycle, plus the PIPE_DLY=2 vs 0 shift check.
  always @(negedge pixel_clk) begin
    exp_t a, w;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        w = sbq[i];
        a = get_act(w.dut);
        n_chk++;
        if (same_out(a, w)) n_pass++;
        else report("vector", a, w);
        sbq.delete(i);
      end
    end
    if (cyc < 2048) hist[cyc] = get_act(0);
    if (cyc >= 3 && cyc <= 1900) begin
      a = get_act(1);
      w = hist[cyc-2];
      w.dut = 1;
      n_chk++;
      if (same_out(a, w)) n_pass++;
      else report("pipe_shift", a, w);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge pixel_clk);
  endtask

  initial begin
    // dut 0: defaults, PIPE_DLY=0 (pixel p shows at cycle p+1)
    e(0,    0, 1,1,0,   0,0, 0,0, 0);
    e(1,    0, 1,1,1,   0,0, 1,1, 0);
    e(2,    0, 1,1,1,   1,0, 0,0, 0);
    e(640,  0, 1,1,1, 639,0, 0,0, 0);
    e(641,  0, 1,1,0, 640,0, 0,0, 0);
    e(656,  0, 1,1,0, 655,0, 0,0, 0);
    e(657,  0, 0,1,0, 656,0, 0,0, 0);
    e(752,  0, 0,1,0, 751,0, 0,0, 0);
    e(753,  0, 1,1,0, 752,0, 0,0, 0);
    e(800,  0, 1,1,0, 799,0, 0,0, 0);
    e(801,  0, 1,1,1,   0,1, 1,0, 0);
    e(1101, 0, 1,1,1, 300,1, 0,0, 0);
    e(1102, 0, 1,1,0,   0,0, 0,0, 0);
    e(1111, 0, 1,1,0,   0,0, 0,0, 0);
    e(1112, 0, 1,1,1,   0,0, 1,1, 0);
    e(1768, 0, 0,1,0, 656,0, 0,0, 0);
    // dut 1: PIPE_DLY=2
    e(0,    1, 1,1,0,   0,0, 0,0, 0);
    e(2,    1, 1,1,0,   0,0, 0,0, 0);
    e(3,    1, 1,1,1,   0,0, 1,1, 0);
    e(659,  1, 0,1,0, 656,0, 0,0, 0);
    e(1103, 1, 1,1,1, 300,1, 0,0, 0);
    e(1104, 1, 1,1,0,   0,0, 0,0, 0);
    e(1113, 1, 1,1,0,   0,0, 0,0, 0);
    e(1114, 1, 1,1,1,   0,0, 1,1, 0);
    // dut 2: small timing, active-high syncs (H_TOT=7, V_TOT=5)
    e(0,  2, 0,0,0, 0,0, 0,0, 0);
    e(1,  2, 0,0,1, 0,0, 1,1, 0);
    e(6,  2, 1,0,0, 5,0, 0,0, 0);
    e(7,  2, 0,0,0, 6,0, 0,0, 0);
    e(22, 2, 0,1,0, 0,3, 1,0, 0);
    e(27, 2, 1,1,0, 5,3, 0,0, 0);
    e(29, 2, 0,0,0, 0,4, 1,0, 0);
    e(36, 2, 0,0,1, 0,0, 1,1, 1);
    // dut 3: small timing, FRAME_W=2, run stop/restart and async reset
    e(0,   3, 1,1,0, 0,0, 0,0, 0);
    e(1,   3, 1,1,1, 0,0, 1,1, 0);
    e(35,  3, 1,1,0, 6,4, 0,0, 0);
    e(36,  3, 1,1,1, 0,0, 1,1, 1);
    e(46,  3, 1,1,1, 3,1, 0,0, 1);
    e(47,  3, 1,1,0, 0,0, 0,0, 1);
    e(49,  3, 1,1,0, 0,0, 0,0, 1);
    e(50,  3, 1,1,1, 0,0, 1,1, 1);
    e(71,  3, 1,0,0, 0,3, 1,0, 1);
    e(76,  3, 0,0,0, 5,3, 0,0, 1);
    e(85,  3, 1,1,1, 0,0, 1,1, 2);
    e(120, 3, 1,1,1, 0,0, 1,1, 3);
    e(154, 3, 1,1,0, 6,4, 0,0, 3);
    e(155, 3, 1,1,1, 0,0, 1,1, 0);
    e(190, 3, 1,1,1, 0,0, 1,1, 1);
    e(193, 3, 1,1,1, 3,0, 0,0, 1);
    e(194, 3, 1,1,0, 0,0, 0,0, 0);
    e(197, 3, 1,1,0, 0,0, 0,0, 0);
    e(200, 3, 1,1,1, 0,0, 1,1, 0);
    e(201, 3, 1,1,1, 1,0, 0,0, 0);

    #22;
    rst_a = 1'b0;
    rst_s = 1'b0;
    wait_cyc(46);  #1 run_s = 1'b0;
    wait_cyc(49);  #1 run_s = 1'b1;
    // land the reset 2 time units after the edge that starts cycle 194
    wait_cyc(193); #7 rst_s = 1'b1;
    wait_cyc(199); #1 rst_s = 1'b0;
    wait_cyc(1101); #1 run_a = 1'b0;
    wait_cyc(1111); #1 run_a = 1'b1;
    wait_cyc(2000);
    #1;
    foreach (sbq[i]) begin
      n_chk++;
      $display("FAIL unchecked cyc=%0d dut=%0d never reached (now cyc=%0d)", sbq[i].cyc, sbq[i].dut, cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
